// File: rtl/matrix_mac_if.sv
// Load, handshake and result-read signals of the matrix MAC engine.
interface matrix_mac_if #(
    parameter int unsigned N  = 2,
    parameter int unsigned DW = 8
);
    localparam int unsigned AW = $clog2(N * N);
    localparam int unsigned RW = 2 * DW + $clog2(N);

    logic          load_en;
    logic          load_sel;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;
    logic          start;
    logic          sgn;
    logic          busy;
    logic          done;
    logic [AW-1:0] rd_addr;
    logic [RW-1:0] rd_data;

    modport master (
        output load_en, load_sel, load_addr, load_data, start, sgn, rd_addr,
        input  busy, done, rd_data
    );

    modport slave (
        input  load_en, load_sel, load_addr, load_data, start, sgn, rd_addr,
        output busy, done, rd_data
    );
endinterface

// File: rtl/matrix_mac_engine.sv
// N x N integer matrix multiplier C = A*B using one time-shared MAC,
// one multiply-accumulate per cycle in k-fastest, then j, then i order.
module matrix_mac_engine #(
    parameter int unsigned N  = 2,
    parameter int unsigned DW = 8
) (
    input  logic        clk,
    input  logic        reset,
    matrix_mac_if.slave bus
);
    localparam int unsigned NE = N * N;
    localparam int unsigned AW = $clog2(NE);
    localparam int unsigned CW = $clog2(N);
    localparam int unsigned PW = 2 * DW;
    localparam int unsigned RW = PW + CW;
    localparam int unsigned XW = RW - PW;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t state, next_state;

    logic [DW-1:0] a_mat [NE];
    logic [DW-1:0] b_mat [NE];
    logic [RW-1:0] c_mat [NE];
    logic [CW-1:0] i_cnt, j_cnt, k_cnt;
    logic [RW-1:0] acc;
    logic          sgn_q;
    logic          busy_q;
    logic          done_q;

    logic          last_i_c, last_j_c, last_k_c, last_mac_c;
    logic [AW-1:0] a_idx_c, b_idx_c, c_idx_c;
    logic [DW-1:0] a_op_c, b_op_c;
    logic [PW-1:0] a_ext_c, b_ext_c, prod_c;
    logic [RW-1:0] term_c, sum_c;
    logic          load_ok_c, rd_ok_c;

    always_comb begin
        last_i_c   = (i_cnt == CW'(N - 1));
        last_j_c   = (j_cnt == CW'(N - 1));
        last_k_c   = (k_cnt == CW'(N - 1));
        last_mac_c = last_i_c && last_j_c && last_k_c;
        a_idx_c    = AW'(32'(i_cnt) * N + 32'(k_cnt));
        b_idx_c    = AW'(32'(k_cnt) * N + 32'(j_cnt));
        c_idx_c    = AW'(32'(i_cnt) * N + 32'(j_cnt));
        load_ok_c  = ({1'b0, bus.load_addr} < (AW+1)'(NE));
        rd_ok_c    = ({1'b0, bus.rd_addr} < (AW+1)'(NE));
    end

    // Product of the operands extended to 2*DW: the low 2*DW bits of a
    // sign-extended product are exactly the signed product.
    always_comb begin
        a_op_c  = a_mat[a_idx_c];
        b_op_c  = b_mat[b_idx_c];
        a_ext_c = {{DW{sgn_q & a_op_c[DW-1]}}, a_op_c};
        b_ext_c = {{DW{sgn_q & b_op_c[DW-1]}}, b_op_c};
        prod_c  = a_ext_c * b_ext_c;
        term_c  = {{XW{sgn_q & prod_c[PW-1]}}, prod_c};
        sum_c   = ((k_cnt == '0) ? '0 : acc) + term_c;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = COMPUTE;
            COMPUTE: if (last_mac_c) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Operand storage, MAC datapath, counters and registered status.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int e = 0; e < int'(NE); e++) begin
                a_mat[e] <= '0;
                b_mat[e] <= '0;
                c_mat[e] <= '0;
            end
            i_cnt  <= '0;
            j_cnt  <= '0;
            k_cnt  <= '0;
            acc    <= '0;
            sgn_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            if (state == IDLE && bus.load_en && load_ok_c) begin
                if (bus.load_sel) b_mat[bus.load_addr] <= bus.load_data;
                else              a_mat[bus.load_addr] <= bus.load_data;
            end
            if (state == IDLE && bus.start) begin
                for (int e = 0; e < int'(NE); e++) c_mat[e] <= '0;
                sgn_q <= bus.sgn;
                i_cnt <= '0;
                j_cnt <= '0;
                k_cnt <= '0;
                acc   <= '0;
            end
            if (state == COMPUTE) begin
                acc   <= sum_c;
                k_cnt <= last_k_c ? '0 : k_cnt + CW'(1);
                if (last_k_c) begin
                    c_mat[c_idx_c] <= sum_c;
                    j_cnt <= last_j_c ? '0 : j_cnt + CW'(1);
                    if (last_j_c) i_cnt <= last_i_c ? '0 : i_cnt + CW'(1);
                end
            end
            busy_q <= (next_state == COMPUTE);
            done_q <= (next_state == DONE);
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;

    // Results are hidden while a computation is rewriting them.
    always_comb begin
        bus.rd_data = '0;
        if (!busy_q && rd_ok_c) bus.rd_data = c_mat[bus.rd_addr];
    end
endmodule

// File: tb/tb_matrix_mac_engine.sv
// Bench for matrix_mac_engine: directed vector table, handshake/reset
// sequences, randomized runs against a loop-based model, and an N=3 instance.
module tb_matrix_mac_engine;
    typedef struct packed {
        logic [3:0][7:0]  a;
        logic [3:0][7:0]  b;
        logic             sgn;
        logic [3:0][16:0] c;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    matrix_mac_if #(.N(2), .DW(8)) m2 ();
    matrix_mac_if #(.N(3), .DW(8)) m3 ();

    matrix_mac_engine #(.N(2), .DW(8)) dut2 (.clk(clk), .reset(reset), .bus(m2));
    matrix_mac_engine #(.N(3), .DW(8)) dut3 (.clk(clk), .reset(reset), .bus(m3));

    int   n_checks = 0;
    int   n_fail   = 0;
    int   mdl_a [4];
    int   mdl_b [4];
    bit   mdl_sgn;
    vec_t vecs [4];
    int   cnt;
    int   pulses;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic longint sval(input int v);
        return (mdl_sgn && v >= 128) ? longint'(v - 256) : longint'(v);
    endfunction

    // C[e] = sum_k A[i][k]*B[k][j], reduced to the 17-bit result width.
    function automatic logic [63:0] model_c2(input int e);
        longint sum = 0;
        int i = e / 2;
        int j = e % 2;
        for (int k = 0; k < 2; k++) sum += sval(mdl_a[i*2+k]) * sval(mdl_b[k*2+j]);
        return 64'(sum) & 64'h1FFFF;
    endfunction

    task automatic clear_model();
        for (int e = 0; e < 4; e++) begin
            mdl_a[e] = 0;
            mdl_b[e] = 0;
        end
    endtask

    task automatic load2(input bit sel, input int addr, input int data);
        @(negedge clk);
        m2.start     = 1'b0;
        m2.load_en   = 1'b1;
        m2.load_sel  = sel;
        m2.load_addr = 2'(addr);
        m2.load_data = 8'(data);
        if (sel) mdl_b[addr] = data & 255;
        else     mdl_a[addr] = data & 255;
    endtask

    task automatic start2(input bit s, input bit ld, input bit lsel, input int laddr, input int ldata);
        @(negedge clk);
        m2.start     = 1'b1;
        m2.sgn       = s;
        m2.load_en   = ld;
        m2.load_sel  = lsel;
        m2.load_addr = 2'(laddr);
        m2.load_data = 8'(ldata);
        mdl_sgn = s;
        if (ld) begin
            if (lsel) mdl_b[laddr] = ldata & 255;
            else      mdl_a[laddr] = ldata & 255;
        end
    endtask

    task automatic wait_done2(input string name);
        int c = 0;
        @(negedge clk);
        m2.start   = 1'b0;
        m2.load_en = 1'b0;
        m2.rd_addr = 2'd0;
        while (m2.done !== 1'b1 && c < 100) begin
            #1;
            chk({name, "_busy"}, 64'(m2.busy), 64'd1);
            chk({name, "_rd_hidden"}, 64'(m2.rd_data), 64'd0);
            @(negedge clk);
            c++;
        end
        chk({name, "_latency"}, 64'(c), 64'd8);
        chk({name, "_done_busy"}, 64'(m2.busy), 64'd0);
        @(negedge clk);
        chk({name, "_done_pulse"}, 64'(m2.done), 64'd0);
    endtask

    task automatic check_c2(input string name);
        for (int e = 0; e < 4; e++) begin
            m2.rd_addr = 2'(e);
            #1;
            chk(name, 64'(m2.rd_data), model_c2(e));
        end
    endtask

    initial begin
        vecs[0].a = {8'd4, 8'd3, 8'd2, 8'd1};
        vecs[0].b = {8'd8, 8'd7, 8'd6, 8'd5};
        vecs[0].sgn = 1'b0;
        vecs[0].c = {17'd50, 17'd43, 17'd22, 17'd19};
        vecs[1].a = {4{8'hFF}};
        vecs[1].b = {4{8'hFF}};
        vecs[1].sgn = 1'b0;
        vecs[1].c = {4{17'd130050}};
        vecs[2].a = {8'hFC, 8'd3, 8'd2, 8'hFF};
        vecs[2].b = {8'd8, 8'd7, 8'd6, 8'd5};
        vecs[2].sgn = 1'b1;
        vecs[2].c = {17'h1FFF2, 17'h1FFF3, 17'd10, 17'd9};
        vecs[3].a = {4{8'h80}};
        vecs[3].b = {4{8'h80}};
        vecs[3].sgn = 1'b1;
        vecs[3].c = {4{17'd32768}};

        {m2.load_en, m2.load_sel, m2.start, m2.sgn} = '0;
        m2.load_addr = '0; m2.load_data = '0; m2.rd_addr = '0;
        {m3.load_en, m3.load_sel, m3.start, m3.sgn} = '0;
        m3.load_addr = '0; m3.load_data = '0; m3.rd_addr = '0;
        clear_model();
        mdl_sgn = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        chk("reset_busy", 64'(m2.busy), 64'd0);
        chk("reset_done", 64'(m2.done), 64'd0);
        chk("reset_rd", 64'(m2.rd_data), 64'd0);
        reset = 1'b1;

        // Directed vector table.
        for (int v = 0; v < 4; v++) begin
            for (int e = 0; e < 4; e++) load2(1'b0, e, int'(vecs[v].a[e]));
            for (int e = 0; e < 4; e++) load2(1'b1, e, int'(vecs[v].b[e]));
            start2(vecs[v].sgn, 1'b0, 1'b0, 0, 0);
            wait_done2($sformatf("vec%0d", v));
            for (int e = 0; e < 4; e++) begin
                m2.rd_addr = 2'(e);
                #1;
                chk($sformatf("vec%0d_c%0d", v, e), 64'(m2.rd_data), 64'(vecs[v].c[e]));
            end
        end

        // Load and start pulsed during COMPUTE; start held across DONE.
        for (int e = 0; e < 4; e++) load2(1'b0, e, int'(vecs[0].a[e]));
        for (int e = 0; e < 4; e++) load2(1'b1, e, int'(vecs[0].b[e]));
        start2(1'b0, 1'b0, 1'b0, 0, 0);
        repeat (2) @(negedge clk);
        m2.load_en = 1'b1; m2.load_sel = 1'b0; m2.load_addr = 2'd0; m2.load_data = 8'd99;
        @(negedge clk);
        m2.load_en = 1'b0;
        cnt = 2;
        while (m2.done !== 1'b1 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        chk("hs_latency", 64'(cnt), 64'd8);
        @(negedge clk);
        m2.start = 1'b0;
        chk("hs_no_retrigger_busy", 64'(m2.busy), 64'd0);
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (m2.done === 1'b1 || m2.busy === 1'b1) pulses++;
        end
        chk("hs_extra_activity", 64'(pulses), 64'd0);
        check_c2("hs_result");

        // Reset asserted three cycles into a computation.
        start2(1'b0, 1'b0, 1'b0, 0, 0);
        repeat (3) @(negedge clk);
        m2.start = 1'b0;
        reset = 1'b0;
        clear_model();
        #1;
        chk("rst_mid_busy", 64'(m2.busy), 64'd0);
        chk("rst_mid_done", 64'(m2.done), 64'd0);
        for (int e = 0; e < 4; e++) begin
            m2.rd_addr = 2'(e);
            #1;
            chk($sformatf("rst_mid_c%0d", e), 64'(m2.rd_data), 64'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int e = 0; e < 4; e++) load2(1'b1, e, int'(vecs[0].b[e]));
        start2(1'b0, 1'b0, 1'b0, 0, 0);
        wait_done2("rst_a_cleared");
        check_c2("rst_a_cleared_c");
        for (int e = 0; e < 4; e++) load2(1'b0, e, int'(vecs[0].a[e]));
        start2(1'b0, 1'b0, 1'b0, 0, 0);
        wait_done2("rst_reload");
        check_c2("rst_reload_c");
        @(negedge clk);
        reset = 1'b0;
        clear_model();
        @(negedge clk);
        reset = 1'b1;
        for (int e = 0; e < 4; e++) load2(1'b0, e, int'(vecs[0].a[e]));
        start2(1'b0, 1'b0, 1'b0, 0, 0);
        wait_done2("rst_b_cleared");
        check_c2("rst_b_cleared_c");

        // Randomized runs, partial reloads and occasional load-with-start.
        for (int r = 0; r < 24; r++) begin
            for (int e = 0; e < 4; e++) begin
                if ($urandom_range(0, 3) != 0) load2(1'b0, e, int'($urandom_range(0, 255)));
                if ($urandom_range(0, 3) != 0) load2(1'b1, e, int'($urandom_range(0, 255)));
            end
            start2(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
            wait_done2($sformatf("rnd%0d", r));
            check_c2($sformatf("rnd%0d_c", r));
        end

        // N=3: identity times 1..9, plus an ignored out-of-range load.
        for (int e = 0; e < 9; e++) begin
            @(negedge clk);
            m3.load_en = 1'b1; m3.load_sel = 1'b0;
            m3.load_addr = 4'(e); m3.load_data = (e % 4 == 0) ? 8'd1 : 8'd0;
        end
        for (int e = 0; e < 9; e++) begin
            @(negedge clk);
            m3.load_sel = 1'b1; m3.load_addr = 4'(e); m3.load_data = 8'(e + 1);
        end
        @(negedge clk);
        m3.load_sel = 1'b0; m3.load_addr = 4'd12; m3.load_data = 8'd77;
        @(negedge clk);
        m3.load_en = 1'b0; m3.start = 1'b1; m3.sgn = 1'b0;
        @(negedge clk);
        m3.start = 1'b0;
        cnt = 0;
        while (m3.done !== 1'b1 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        chk("n3_latency", 64'(cnt), 64'd27);
        @(negedge clk);
        for (int e = 0; e < 16; e++) begin
            m3.rd_addr = 4'(e);
            #1;
            chk($sformatf("n3_c%0d", e), 64'(m3.rd_data), (e < 9) ? 64'(e + 1) : 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
